// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: lane steering, load extension, misalignment faults
// and bus timeout around a single-outstanding handshaked data-memory bus.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] alu_in,
  input  logic [31:0] wdata_in,
  input  logic [2:0]  funct3_in,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  output logic        stall_out,
  output logic [31:0] load_data_out,
  output logic        load_valid,
  output logic        access_fault,
  output logic        timeout_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   load_data_q, load_data_d;
  logic [3:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [1:0]    off_q, off_d;
  logic [2:0]    f3_q, f3_d;
  logic          load_valid_q, load_valid_d;
  logic          access_fault_q, access_fault_d;
  logic          timeout_err_q, timeout_err_d;

  logic          access, f3_legal, misaligned, fault;
  logic          stall_c, req_c;
  logic [3:0]    be_calc;
  logic [31:0]   wdata_calc;

  function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                               input logic [1:0]  off,
                                               input logic [2:0]  f3);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'd0, sh[7:0]};
      3'b101:  return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Decode of the access presented by EX/MEM; a set MemWriteM always means store.
  always_comb begin
    access = MemWriteM | MemtoRegM;
    case (funct3_in)
      3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
      3'b100, 3'b101:         f3_legal = ~MemWriteM;
      default:                f3_legal = 1'b0;
    endcase
    misaligned = ((funct3_in[1:0] == 2'b01) && alu_in[0]) ||
                 ((funct3_in == 3'b010) && (alu_in[1:0] != 2'b00));
    fault = access & (~f3_legal | misaligned);
    case (funct3_in[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << alu_in[1:0];
        wdata_calc = {4{wdata_in[7:0]}};
      end
      2'b01: begin
        be_calc    = alu_in[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata_in[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata_in;
      end
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    be_d           = be_q;
    we_d           = we_q;
    off_d          = off_q;
    f3_d           = f3_q;
    load_data_d    = load_data_q;
    load_valid_d   = 1'b0;
    access_fault_d = 1'b0;
    timeout_err_d  = 1'b0;
    stall_c        = 1'b0;
    req_c          = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (access && !fault) begin
          stall_c = 1'b1;
          state_d = S_REQ;
          cnt_d   = '0;
          addr_d  = {alu_in[31:2], 2'b00};
          be_d    = be_calc;
          we_d    = MemWriteM;
          wdata_d = wdata_calc;
          off_d   = alu_in[1:0];
          f3_d    = funct3_in;
        end else if (access) begin
          access_fault_d = 1'b1;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        req_c   = 1'b1;
        // Ready on the final allowed cycle still counts as a completion.
        if (dmem_ready) begin
          state_d = S_DONE;
          if (!we_q) begin
            load_valid_d = 1'b1;
            load_data_d  = extract_load(dmem_rdata, off_q, f3_q);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = S_DONE;
          timeout_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        addr_d  = '0;
        wdata_d = '0;
        be_d    = '0;
        we_d    = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      be_q           <= '0;
      we_q           <= 1'b0;
      off_q          <= '0;
      f3_q           <= '0;
      load_data_q    <= '0;
      load_valid_q   <= 1'b0;
      access_fault_q <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      be_q           <= be_d;
      we_q           <= we_d;
      off_q          <= off_d;
      f3_q           <= f3_d;
      load_data_q    <= load_data_d;
      load_valid_q   <= load_valid_d;
      access_fault_q <= access_fault_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Stall is gated by reset so nothing is requested while rst_n is low.
  assign stall_out     = stall_c & rst_n;
  assign dmem_req      = req_c;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_be       = be_q;
  assign dmem_wdata    = wdata_q;
  assign load_data_out = load_data_q;
  assign load_valid    = load_valid_q;
  assign access_fault  = access_fault_q;
  assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu against a transaction-level reference model.
module tb_mem_stage_lsu;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] alu_in, wdata_in, dmem_rdata;
  logic [2:0]  funct3_in;
  logic        MemWriteM, MemtoRegM, dmem_ready;
  logic        stall_out, load_valid, access_fault, timeout_err;
  logic        dmem_req, dmem_we;
  logic [31:0] load_data_out, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_ld = 32'd0;

  mem_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .alu_in(alu_in), .wdata_in(wdata_in),
    .funct3_in(funct3_in), .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM),
    .stall_out(stall_out), .load_data_out(load_data_out), .load_valid(load_valid),
    .access_fault(access_fault), .timeout_err(timeout_err), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Access width in bytes, or 0 when the funct3 is not allowed for this direction.
  function automatic int size_of(input bit st, input bit [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd2: return 4;
      3'd4: return st ? 0 : 1;
      3'd5: return st ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                             input int bytes, input bit sgn);
    logic [31:0] v, mask;
    v = rdata >> (8 * off);
    if (bytes == 4) return v;
    mask = (32'd1 << (8 * bytes)) - 32'd1;
    v = v & mask;
    if (sgn && v[8*bytes-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input int bytes);
    logic [31:0] r, val;
    if (bytes == 4) return wd;
    val = wd & ((32'd1 << (8 * bytes)) - 32'd1);
    r = 32'd0;
    for (int i = 0; i < 4 / bytes; i++) r = r | (val << (8 * bytes * i));
    return r;
  endfunction

  task automatic do_access(input bit st, input bit ld, input bit [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int wt, input logic [31:0] rdata);
    int bytes, n;
    bit legal, success, done;
    logic [3:0] ebe;
    bytes   = size_of(st, f3);
    legal   = (bytes != 0) && ((a % bytes) == 0);
    success = (wt < TIMEOUT);
    ebe     = legal ? 4'(((1 << bytes) - 1) << (a % 4)) : 4'd0;
    @(negedge clk);
    alu_in = a; wdata_in = wd; funct3_in = f3; MemWriteM = st; MemtoRegM = ld;
    dmem_ready = 1'b0;
    #1;
    chk("stall_idle", stall_out, legal);
    chk("req_idle", dmem_req, 1'b0);
    if (!legal) begin
      dmem_ready = 1'($urandom);
      @(negedge clk);
      chk("fault_pulse", access_fault, 1'b1);
      chk("fault_req", dmem_req, 1'b0);
      chk("fault_ld", load_data_out, exp_ld);
      MemWriteM = 1'b0; MemtoRegM = 1'b0; dmem_ready = 1'b0;
      @(negedge clk);
      chk("fault_width", access_fault, 1'b0);
      chk("fault_stall", stall_out, 1'b0);
      return;
    end
    n = 0; done = 1'b0;
    while (!done) begin
      @(negedge clk);
      chk("req", dmem_req, 1'b1);
      chk("stall_req", stall_out, 1'b1);
      chk("addr", dmem_addr, {a[31:2], 2'b00});
      chk("be", dmem_be, ebe);
      chk("we", dmem_we, st);
      if (st) chk("wdata", dmem_wdata, model_wdata(wd, bytes));
      dmem_ready = (n == wt);
      dmem_rdata = (n == wt) ? rdata : $urandom;
      if (n == wt || n == TIMEOUT - 1) done = 1'b1;
      n++;
    end
    @(negedge clk);
    dmem_ready = 1'($urandom);
    dmem_rdata = $urandom;
    if (success && !st) exp_ld = model_load(rdata, a % 4, bytes, f3 < 3'd4);
    chk("stall_done", stall_out, 1'b0);
    chk("req_done", dmem_req, 1'b0);
    chk("load_valid", load_valid, success && !st);
    chk("timeout_err", timeout_err, !success);
    chk("load_data", load_data_out, exp_ld);
    MemWriteM = 1'b0; MemtoRegM = 1'b0;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("lv_width", load_valid, 1'b0);
    chk("to_width", timeout_err, 1'b0);
    chk("idle_addr", dmem_addr, 32'd0);
    chk("idle_be", dmem_be, 4'd0);
    chk("idle_we", dmem_we, 1'b0);
  endtask

  initial begin
    int wt;
    bit st, ld;
    rst_n = 1'b0; alu_in = 32'h1000; wdata_in = 32'd0; funct3_in = 3'd2;
    MemWriteM = 1'b0; MemtoRegM = 1'b1; dmem_ready = 1'b0; dmem_rdata = 32'd0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall_out, 1'b0);
    chk("rst_req", dmem_req, 1'b0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_ld", load_data_out, 32'd0);
    chk("rst_pulses", {29'd0, load_valid, access_fault, timeout_err}, 32'd0);
    MemtoRegM = 1'b0;
    rst_n = 1'b1;

    do_access(1'b0, 1'b1, 3'd2, 32'h1000, 32'd0, 0, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 3'd0, 32'h1003, 32'd0, 0, 32'h80123456);
    do_access(1'b0, 1'b1, 3'd4, 32'h1003, 32'd0, 1, 32'h80123456);
    do_access(1'b1, 1'b0, 3'd1, 32'h2002, 32'h1234ABCD, 0, 32'h0);
    do_access(1'b0, 1'b1, 3'd2, 32'h1001, 32'd0, 0, 32'h0);
    do_access(1'b1, 1'b0, 3'd4, 32'h2000, 32'h55, 0, 32'h0);
    do_access(1'b0, 1'b1, 3'd2, 32'h1004, 32'd0, TIMEOUT + 5, 32'h0);
    do_access(1'b0, 1'b1, 3'd5, 32'h1006, 32'd0, TIMEOUT - 1, 32'hC0DE8001);
    do_access(1'b1, 1'b1, 3'd0, 32'h3001, 32'hA5, 2, 32'h0);

    // Reset asserted during the third REQ cycle of a never-answered load.
    @(negedge clk);
    alu_in = 32'h3000; funct3_in = 3'd2; MemtoRegM = 1'b1; MemWriteM = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_req", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", dmem_req, 1'b0);
    chk("midrst_stall", stall_out, 1'b0);
    chk("midrst_ld", load_data_out, 32'd0);
    exp_ld = 32'd0;
    @(negedge clk);
    rst_n = 1'b1; MemtoRegM = 1'b0;
    repeat (TIMEOUT + 2) begin
      @(negedge clk);
      chk("post_rst_quiet", {28'd0, load_valid, timeout_err, dmem_req, stall_out}, 32'd0);
    end

    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom);
      ld = st ? 1'($urandom) : 1'b1;
      case ($urandom_range(0, 9))
        0:       wt = TIMEOUT - 1;
        1:       wt = TIMEOUT + 2;
        default: wt = $urandom_range(0, 3);
      endcase
      do_access(st, ld, 3'($urandom), $urandom, $urandom, wt, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
# mem_stage_lsu

Load/store unit for the MEM stage of the pipelined RV32I core. It consumes the EX/MEM pipeline register outputs (ALU result as address, RD2 as store data, funct3, MemWriteM/MemtoRegM) and drives a handshaked data-memory bus. It handles byte-lane steering, load sign/zero extension, misalignment faults and bus timeouts. It holds `stall_out` high so the pipeline freezes while a bus access is in flight.

## Interface
- `TIMEOUT`, default 16: maximum number of REQ-state cycles without `dmem_ready` before the access is abandoned (≥2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `alu_in`  in  32  effective address (ALU result from EX/MEM).
- `wdata_in`  in  32  store data (RD2 from EX/MEM).
- `funct3_in`  in  3  access size/sign.
- `MemWriteM`  in  1  store request.
- `MemtoRegM`  in  1  load request.
- `stall_out`  out  1  freeze IF/ID/EX/MEM registers.
- `load_data_out`  out  32  extended load result, held until next completed load.
- `load_valid`  out  1  one-cycle pulse, load result updated.
- `access_fault`  out  1  one-cycle pulse, misaligned or illegal funct3.
- `timeout_err`  out  1  one-cycle pulse, bus timeout.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word address, `{alu_in[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ready`  in  1  bus completes access this cycle.
- `dmem_rdata`  in  32  read word, valid when `dmem_ready`=1 and `dmem_we`=0.

## Operation
- funct3 map: 000 B (signed load), 001 H (signed), 010 W, 100 BU, 101 HU. 100/101 are legal only for loads. Any other code is illegal.
- When both MemWriteM and MemtoRegM are set, the access is a store.
- Misaligned accesses:
  - H/HU with `alu_in[0]`=1.
  - W with `alu_in[1:0]`≠00.
- Byte enables:
  - B: `4'b0001<<alu_in[1:0]`.
  - H: `alu_in[1]` ? 1100 : 0011.
  - W: 1111.
- Store data:
  - B: `{4{wdata_in[7:0]}}`.
  - H: `{2{wdata_in[15:0]}}`.
  - W: unchanged.
- Load extraction:
  - Byte select is `rdata>>(8*offset)`, with `offset` = `alu_in[1:0]` captured at issue.
  - B/H sign-extend bit 7/15; BU/HU zero-extend.
- FSM states:
  - IDLE:
    - Legal, aligned access present: `stall_out`=1 combinationally; next state REQ. Address, be, we, wdata, offset and funct3 are registered.
    - Faulting access: no request, `stall_out`=0; `access_fault`=1 next cycle; stay IDLE.
    - No access: stay IDLE.
  - REQ: `dmem_req`=1, `stall_out`=1, wait counter increments each cycle.
    - On an edge with `dmem_ready`=1: go to DONE. For a load, `load_data_out` is updated and `load_valid`=1 in DONE.
    - If the counter reaches `TIMEOUT` without ready: go to DONE, `timeout_err`=1 in DONE, `load_data_out` unchanged, `load_valid`=0.
  - DONE: `stall_out`=0, `dmem_req`=0, no new access is sampled. The pipeline advances at the end of this cycle. Next state IDLE.
- Bus outputs `dmem_addr`/`be`/`we`/`wdata` are registered and held stable through REQ. They are don't-care outside REQ, but driven to 0 in IDLE.

## Timing
- Reset values (asynchronous, on `rst_n`=0):
  - State IDLE, counter 0.
  - `dmem_req`, `dmem_we`, `dmem_be`, `dmem_addr`, `dmem_wdata` = 0.
  - `load_data_out`=0; `load_valid`, `access_fault`, `timeout_err` = 0.
  - `stall_out`=0 (no access is sampled while in reset).
- Reset mid-REQ: `dmem_req` drops immediately; no pulse is emitted after release.
- Latency with zero-wait memory: access seen in cycle T (IDLE), REQ in T+1 with ready, DONE in T+2. This gives 2 stall cycles, with `load_valid` in T+2.
- Each wait cycle of `dmem_ready`=0 adds one stall cycle.
- Back-to-back memory instructions: the second is sampled in the IDLE cycle that follows DONE (T+3).
- `dmem_ready` outside REQ is ignored.
- Timeout:
  - `timeout_err` appears in the cycle after the `TIMEOUT`-th REQ cycle.
  - A ready arriving on that same edge wins and counts as completion.
- Fault pulses are registered: one cycle after the faulting IDLE cycle, exactly one cycle wide.

## Test plan
- LW, `alu_in`=0x1000, ready in first REQ cycle, rdata=0xDEADBEEF -> `dmem_addr`=0x1000, be=1111, we=0. Stall for 2 cycles, then `load_data_out`=0xDEADBEEF and `load_valid` pulse.
- LB at 0x1003 with rdata=0x80123456 -> be=1000, `load_data_out`=0xFFFFFF80. Same access as LBU -> 0x00000080.
- SH at 0x2002, `wdata_in`=0x1234ABCD -> we=1, be=1100, `dmem_wdata`=0xABCDABCD. No `load_valid`; `load_data_out` unchanged.
- LW at 0x1001 and SB with funct3=100 -> no `dmem_req`, `stall_out`=0, one-cycle `access_fault` each.
- LW with `dmem_ready` held 0 and TIMEOUT=16 -> 16 REQ cycles, `timeout_err` pulse, return to IDLE, `load_data_out` unchanged.
- `rst_n` asserted in the 3rd REQ cycle -> `dmem_req` and `stall_out` low immediately. After release, state is IDLE and no stale `load_valid` appears.
